// File: rtl/store_write_buffer_pkg.sv
// Shared definitions for the store write buffer: size encodings, entry layout, drain FSM states.
// Replaces the legacy store_buffer_defs.v header; 98-bit entry = {addr, data, size}.
package store_write_buffer_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_WORD  = 2'b01;
    localparam logic [1:0] SZ_DWORD = 2'b10;
    localparam logic [1:0] SZ_QWORD = 2'b11;

    localparam int ENTRY_W = 98;

    typedef struct packed {
        logic [31:0] addr;
        logic [63:0] data;
        logic [1:0]  size;
    } swb_entry_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } swb_state_t;

endpackage

// File: rtl/swb_entry_array.sv
// Store entry storage: DEPTH x 98 registers, write port at wr_ptr, read port at rd_ptr, valid bits.
// Latency: write visible at the read port the cycle after the push edge; no backpressure of its own.
// WB_LD_CONFLICT_EN builds the per-entry load-alias comparators; otherwise ld_conflict is 0.
module swb_entry_array
    import store_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_ptr,
    input  swb_entry_t    wr_entry,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_ptr,
    output swb_entry_t    rd_entry,
    input  logic [31:0]   ld_addr,
    output logic          ld_conflict
);

    swb_entry_t           mem [DEPTH];
    logic [DEPTH-1:0]     valid;

    // Payload needs no reset: it is only ever observed behind a valid/REQ qualifier.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else begin
            if (rd_en) begin
                valid[rd_ptr] <= 1'b0;
            end
            if (wr_en) begin
                valid[wr_ptr] <= 1'b1;
            end
        end
    end

    assign rd_entry = mem[rd_ptr];

`ifdef WB_LD_CONFLICT_EN
    logic unused_ld_lo;
    assign unused_ld_lo = ^ld_addr[2:0];

    // Doubleword-granular alias check; the head under REQ is still valid and counts.
    always_comb begin
        ld_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (mem[i].addr[31:3] == ld_addr[31:3])) begin
                ld_conflict = 1'b1;
            end
        end
    end
`else
    logic unused_ld;
    assign unused_ld   = ^{ld_addr, valid};
    assign ld_conflict = 1'b0;
`endif

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer between writeback and the D-cache write port; optional WB_LD_CONFLICT_EN alias check.
// Latency: push at edge N -> DC_WR_REQ from edge N+1; one entry drained per ACKed cycle.
// Backpressure: In_write_ready low when DEPTH entries are held; a same-cycle pop does not free a slot.
module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        WB_Final_Dcache_Write,
    input  logic [31:0] WB_Final_Dcache_Address,
    input  logic [63:0] WB_Final_Dcache_Data,
    input  logic [1:0]  WB_Final_datasize,
    output logic        In_write_ready,
    output logic        DC_WR_REQ,
    output logic [31:0] DC_WR_ADDR,
    output logic [63:0] DC_WR_DATA,
    output logic [1:0]  DC_WR_SIZE,
    input  logic        DC_WR_ACK,
    output logic        SWB_EMPTY,
    input  logic [31:0] LD_ADDR,
    output logic        LD_CONFLICT
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    swb_state_t  state;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          push;
    logic          pop;
    swb_entry_t    wr_entry;
    swb_entry_t    head;

    assign In_write_ready = (count != CNT_MAX);
    assign push           = WB_Final_Dcache_Write && In_write_ready;
    assign pop            = (state == ST_REQ) && DC_WR_ACK;

    assign wr_entry.addr = WB_Final_Dcache_Address;
    assign wr_entry.data = WB_Final_Dcache_Data;
    assign wr_entry.size = WB_Final_datasize;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_ONE;
        end else if (pop && !push) begin
            count_next = count - CNT_ONE;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state <= ST_IDLE;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
            count <= count_next;
            case (state)
                ST_IDLE: if (count != '0) state <= ST_REQ;
                ST_REQ:  if (pop && (count_next == '0)) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    swb_entry_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_entries (
        .clk         (CLK),
        .rst_n       (CLR),
        .wr_en       (push),
        .wr_ptr      (wptr),
        .wr_entry    (wr_entry),
        .rd_en       (pop),
        .rd_ptr      (rptr),
        .rd_entry    (head),
        .ld_addr     (LD_ADDR),
        .ld_conflict (LD_CONFLICT)
    );

    // Head fields read zero outside REQ so a reset-withdrawn request shows nothing stale.
    assign DC_WR_REQ  = (state == ST_REQ);
    assign DC_WR_ADDR = DC_WR_REQ ? head.addr : '0;
    assign DC_WR_DATA = DC_WR_REQ ? head.data : '0;
    assign DC_WR_SIZE = DC_WR_REQ ? head.size : '0;
    assign SWB_EMPTY  = (count == '0) && (state == ST_IDLE);

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: reset, single store, fill/backpressure, streaming wrap,
// mid-operation reset and load-alias reporting (expectation follows WB_LD_CONFLICT_EN).
module tb_store_write_buffer;

`ifdef WB_LD_CONFLICT_EN
    localparam bit CONF_EN = 1'b1;
`else
    localparam bit CONF_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        CLR;
    logic        WB_Final_Dcache_Write;
    logic [31:0] WB_Final_Dcache_Address;
    logic [63:0] WB_Final_Dcache_Data;
    logic [1:0]  WB_Final_datasize;
    logic        In_write_ready;
    logic        DC_WR_REQ;
    logic [31:0] DC_WR_ADDR;
    logic [63:0] DC_WR_DATA;
    logic [1:0]  DC_WR_SIZE;
    logic        DC_WR_ACK;
    logic        SWB_EMPTY;
    logic [31:0] LD_ADDR;
    logic        LD_CONFLICT;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    store_write_buffer #(.DEPTH(4)) dut (
        .CLK                     (CLK),
        .CLR                     (CLR),
        .WB_Final_Dcache_Write   (WB_Final_Dcache_Write),
        .WB_Final_Dcache_Address (WB_Final_Dcache_Address),
        .WB_Final_Dcache_Data    (WB_Final_Dcache_Data),
        .WB_Final_datasize       (WB_Final_datasize),
        .In_write_ready          (In_write_ready),
        .DC_WR_REQ               (DC_WR_REQ),
        .DC_WR_ADDR              (DC_WR_ADDR),
        .DC_WR_DATA              (DC_WR_DATA),
        .DC_WR_SIZE              (DC_WR_SIZE),
        .DC_WR_ACK               (DC_WR_ACK),
        .SWB_EMPTY               (SWB_EMPTY),
        .LD_ADDR                 (LD_ADDR),
        .LD_CONFLICT             (LD_CONFLICT)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit past the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_store(input logic wr, input logic [31:0] a, input logic [63:0] d, input logic [1:0] s);
        WB_Final_Dcache_Write   = wr;
        WB_Final_Dcache_Address = a;
        WB_Final_Dcache_Data    = d;
        WB_Final_datasize       = s;
    endtask

    logic [63:0] exp_q[$];
    int          pops;

    initial begin
        CLR = 1'b0;
        DC_WR_ACK = 1'b0;
        LD_ADDR = 32'h0;
        set_store(1'b0, 32'h0, 64'h0, 2'b00);
        repeat (3) tick();
        CLR = 1'b1;
        tick();

        // Reset then idle
        check_eq("rst_ready", In_write_ready, 1);
        check_eq("rst_empty", SWB_EMPTY, 1);
        check_eq("rst_req",   DC_WR_REQ, 0);
        check_eq("rst_addr",  DC_WR_ADDR, 0);
        check_eq("rst_conf",  LD_CONFLICT, 0);

        // Single store with delayed ACK
        set_store(1'b1, 32'h0000_1008, 64'h1122_3344_5566_7788, 2'b10);
        tick();
        set_store(1'b0, 32'h0, 64'h0, 2'b00);
        check_eq("single_not_empty", SWB_EMPTY, 0);
        tick();
        check_eq("single_req",  DC_WR_REQ, 1);
        check_eq("single_addr", DC_WR_ADDR, 64'h1008);
        check_eq("single_data", DC_WR_DATA, 64'h1122_3344_5566_7788);
        check_eq("single_size", DC_WR_SIZE, 2'b10);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("hold_req",  DC_WR_REQ, 1);
            check_eq("hold_addr", DC_WR_ADDR, 64'h1008);
            check_eq("hold_data", DC_WR_DATA, 64'h1122_3344_5566_7788);
        end
        DC_WR_ACK = 1'b1;
        tick();
        DC_WR_ACK = 1'b0;
        check_eq("single_empty", SWB_EMPTY, 1);
        check_eq("single_req_low", DC_WR_REQ, 0);

        // Fill to DEPTH with ACK held low
        for (int i = 0; i < 4; i++) begin
            check_eq("fill_ready", In_write_ready, 1);
            set_store(1'b1, 32'h100 + 32'(i * 8), 64'(i + 1), 2'b01);
            tick();
        end
        check_eq("full_ready", In_write_ready, 0);
        set_store(1'b1, 32'h500, 64'd5, 2'b01);
        tick();
        check_eq("full_ignore", In_write_ready, 0);
        check_eq("full_head", DC_WR_DATA, 64'd1);
        DC_WR_ACK = 1'b1;
        tick();
        DC_WR_ACK = 1'b0;
        check_eq("ready_after_ack", In_write_ready, 1);
        tick();
        set_store(1'b0, 32'h0, 64'h0, 2'b00);
        check_eq("refull_ready", In_write_ready, 0);
        DC_WR_ACK = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            check_eq("drain_req",  DC_WR_REQ, 1);
            check_eq("drain_data", DC_WR_DATA, 64'(k));
            tick();
        end
        DC_WR_ACK = 1'b0;
        check_eq("drain_empty", SWB_EMPTY, 1);
        check_eq("drain_head5_addr_gone", DC_WR_ADDR, 0);

        // Streaming with ACK always high: pointer wrap, order preserved
        DC_WR_ACK = 1'b1;
        pops = 0;
        for (int c = 0; c < 40; c++) begin
            if (c < 20) set_store(1'b1, 32'(c * 8), 64'hABCD_0000 + 64'(c), 2'b10);
            else        set_store(1'b0, 32'h0, 64'h0, 2'b00);
            if (c < 20) check_eq("stream_ready", In_write_ready, 1);
            if (DC_WR_REQ) begin
                if (exp_q.size() == 0) begin
                    check_eq("stream_spurious_req", DC_WR_REQ, 0);
                end else begin
                    check_eq("stream_data", DC_WR_DATA, exp_q.pop_front());
                    pops++;
                end
            end
            if (WB_Final_Dcache_Write && In_write_ready) exp_q.push_back(WB_Final_Dcache_Data);
            tick();
        end
        DC_WR_ACK = 1'b0;
        check_eq("stream_pops", 64'(pops), 20);
        check_eq("stream_empty", SWB_EMPTY, 1);

        // Reset while three entries pending and REQ high
        for (int i = 0; i < 3; i++) begin
            set_store(1'b1, 32'h3000 + 32'(i * 8), 64'h77 + 64'(i), 2'b11);
            tick();
        end
        set_store(1'b0, 32'h0, 64'h0, 2'b00);
        tick();
        check_eq("prerst_req", DC_WR_REQ, 1);
        #2;
        CLR = 1'b0;
        #1;
        check_eq("arst_req",   DC_WR_REQ, 0);
        check_eq("arst_addr",  DC_WR_ADDR, 0);
        check_eq("arst_data",  DC_WR_DATA, 0);
        check_eq("arst_ready", In_write_ready, 1);
        check_eq("arst_empty", SWB_EMPTY, 1);
        tick();
        #2;
        CLR = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("postrst_req", DC_WR_REQ, 0);
        end
        check_eq("postrst_empty", SWB_EMPTY, 1);

        // Load alias against a pending store
        set_store(1'b1, 32'h2004, 64'hDEAD, 2'b01);
        tick();
        set_store(1'b0, 32'h0, 64'h0, 2'b00);
        LD_ADDR = 32'h2000;
        #1;
        check_eq("conf_same_dw", LD_CONFLICT, CONF_EN);
        LD_ADDR = 32'h2008;
        #1;
        check_eq("conf_next_dw", LD_CONFLICT, 0);
        tick();
        LD_ADDR = 32'h2000;
        #1;
        check_eq("conf_head_req", LD_CONFLICT, CONF_EN);
        check_eq("conf_req", DC_WR_REQ, 1);
        DC_WR_ACK = 1'b1;
        tick();
        DC_WR_ACK = 1'b0;
        #1;
        check_eq("conf_after_ack", LD_CONFLICT, 0);
        check_eq("final_empty", SWB_EMPTY, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
